// File: rtl/mem_pkg.sv
// Shared types and decode helpers for the MEM-stage data-memory access engine.
package mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_t;

  // Registered data-bus request payload, held stable while the transfer is outstanding.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } dbus_req_t;

  // Access width; anything not a defined b/h encoding for the operation is a word.
  function automatic mem_size_t access_size(input logic [2:0] f3, input logic is_store);
    mem_size_t sz;
    sz = SZ_W;
    if (is_store) begin
      if (f3 == F3_B)      sz = SZ_B;
      else if (f3 == F3_H) sz = SZ_H;
    end else begin
      case (f3)
        F3_B, F3_BU: sz = SZ_B;
        F3_H, F3_HU: sz = SZ_H;
        default:     sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (sz)
      SZ_H:    mis = off[0];
      SZ_W:    mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/half from a bus read word and sign/zero extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane select followed by extension chosen by funct3.
  always_comb begin
    byte_c = rdata[{off, 3'b000} +: 8];
    half_c = off[1] ? rdata[31:16] : rdata[15:0];
    data_c = rdata;
    case (funct3)
      F3_B:    data_c = {{24{byte_c[7]}}, byte_c};
      F3_BU:   data_c = {24'h00_0000, byte_c};
      F3_H:    data_c = {{16{half_c[15]}}, half_c};
      F3_HU:   data_c = {16'h0000, half_c};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: turns RV32 loads/stores into a req/ack word
// transfer, stalls the pipeline until completion and returns the extended load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_result,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_error,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  dbus_req_t        bus_q, bus_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      rres_q, rres_d;
  logic             misalign_q, misalign_d;
  logic             bus_error_q, bus_error_d;

  logic             mem_stall_c;
  logic             access_c;
  logic             is_store_c;
  mem_size_t        size_c;
  logic             misaligned_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic             timeout_c;
  logic [31:0]      load_word_c;

  load_align u_load_align (
    .rdata  (dbus_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data_c (load_word_c)
  );

  // Decode the incoming request: store wins over load, byte enables and lane replication.
  always_comb begin
    access_c     = mem_mem_read | mem_mem_write;
    is_store_c   = mem_mem_write;
    size_c       = access_size(mem_funct3, is_store_c);
    misaligned_c = is_misaligned(size_c, mem_alu_result[1:0]);
    be_c         = 4'b1111;
    wdata_c      = '0;
    if (is_store_c) begin
      case (size_c)
        SZ_B: begin
          be_c    = 4'b0001 << mem_alu_result[1:0];
          wdata_c = {4{mem_write_data[7:0]}};
        end
        SZ_H: begin
          be_c    = mem_alu_result[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{mem_write_data[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = mem_write_data;
        end
      endcase
    end
  end

  // Timeout fires only when enabled and the wait counter has reached the limit.
  always_comb begin
    timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
  end

  // Next-state and registered-output logic for IDLE -> REQ -> DONE -> IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    bus_d       = bus_q;
    off_d       = off_q;
    f3_d        = f3_q;
    rres_d      = rres_q;
    misalign_d  = 1'b0;
    bus_error_d = 1'b0;
    mem_stall_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (access_c) begin
          if (misaligned_c) begin
            misalign_d = 1'b1;
          end else begin
            mem_stall_c = 1'b1;
            state_d     = ST_REQ;
            req_d       = 1'b1;
            bus_d.we    = is_store_c;
            bus_d.addr  = {mem_alu_result[31:2], 2'b00};
            bus_d.be    = be_c;
            bus_d.wdata = wdata_c;
            off_d       = mem_alu_result[1:0];
            f3_d        = mem_funct3;
          end
        end
      end

      ST_REQ: begin
        mem_stall_c = 1'b1;
        cnt_d       = cnt_q + CNT_W'(1);
        if (dbus_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          if (!bus_q.we) rres_d = load_word_c;
        end else if (timeout_c) begin
          state_d     = ST_DONE;
          req_d       = 1'b0;
          bus_error_d = 1'b1;
          if (!bus_q.we) rres_d = ERR_DATA;
        end
      end

      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        cnt_d   = '0;
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      bus_q       <= '0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      rres_q      <= '0;
      misalign_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      bus_q       <= bus_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      rres_q      <= rres_d;
      misalign_q  <= misalign_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Stall is combinational so the issuing cycle already holds the pipeline; forced low in reset.
  assign mem_stall       = mem_stall_c & ~rst;
  assign mem_read_result = rres_q;
  assign misalign        = misalign_q;
  assign bus_error       = bus_error_q;
  assign dbus_req        = req_q;
  assign dbus_we         = bus_q.we;
  assign dbus_addr       = bus_q.addr;
  assign dbus_be         = bus_q.be;
  assign dbus_wdata      = bus_q.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard of expected load results.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_result;
  logic        mem_stall;
  logic        misalign;
  logic        bus_error;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_q[$];
  logic [31:0] exp_rres;

  int          stalls;
  bit          saw_req;
  bit          done;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;

  mem_access_unit #(
    .TIMEOUT  (4),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_mem_read    (mem_mem_read),
    .mem_mem_write   (mem_mem_write),
    .mem_funct3      (mem_funct3),
    .mem_alu_result  (mem_alu_result),
    .mem_write_data  (mem_write_data),
    .mem_read_result (mem_read_result),
    .mem_stall       (mem_stall),
    .misalign        (misalign),
    .bus_error       (bus_error),
    .dbus_req        (dbus_req),
    .dbus_we         (dbus_we),
    .dbus_addr       (dbus_addr),
    .dbus_be         (dbus_be),
    .dbus_wdata      (dbus_wdata),
    .dbus_ack        (dbus_ack),
    .dbus_rdata      (dbus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      check(tag, mem_read_result, e);
    end
  endtask

  // Issue one access at a negedge, act as bus slave (ack after ack_lat REQ cycles, -1 = never),
  // and return at the first negedge where the stall has dropped.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdata, input int ack_lat);
    int k;
    @(negedge clk);
    mem_mem_read   = rd;
    mem_mem_write  = wr;
    mem_funct3     = f3;
    mem_alu_result = a;
    mem_write_data = wd;
    #1;
    stalls  = 0;
    saw_req = 1'b0;
    done    = 1'b0;
    k       = 0;
    if (mem_stall) stalls++;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      dbus_ack = 1'b0;
      if (dbus_req) begin
        if (!saw_req) begin
          cap_we    = dbus_we;
          cap_addr  = dbus_addr;
          cap_be    = dbus_be;
          cap_wdata = dbus_wdata;
        end
        saw_req = 1'b1;
        if (k == ack_lat) begin
          dbus_ack   = 1'b1;
          dbus_rdata = rdata;
        end
        k++;
      end
      if (mem_stall) stalls++;
      else done = 1'b1;
    end
    check("access_completes", 32'(done), 32'd1);
    mem_mem_read  = 1'b0;
    mem_mem_write = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    mem_mem_read   = 1'b0;
    mem_mem_write  = 1'b0;
    mem_funct3     = 3'b000;
    mem_alu_result = '0;
    mem_write_data = '0;
    dbus_ack       = 1'b0;
    dbus_rdata     = '0;
    exp_rres       = '0;

    repeat (2) @(negedge clk);
    check("rst_rres",  mem_read_result, 32'h0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_req",   32'(dbus_req), 32'd0);
    check("rst_be",    32'(dbus_be), 32'd0);
    check("rst_mis",   32'(misalign), 32'd0);
    check("rst_berr",  32'(bus_error), 32'd0);
    rst = 1'b0;

    // lw, ack in first REQ cycle
    exp_rres = 32'h1122_3344;
    sb_q.push_back(exp_rres);
    run_access(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 32'h1122_3344, 0);
    check("lw_stalls", 32'(stalls), 32'd2);
    check("lw_addr",   cap_addr, 32'h100);
    check("lw_be",     32'(cap_be), 32'hF);
    check("lw_we",     32'(cap_we), 32'd0);
    pop_check("lw_data");
    @(negedge clk);
    check("lw_hold",   mem_read_result, 32'h1122_3344);
    check("lw_idle_stall", 32'(mem_stall), 32'd0);

    // lb, sign extension, slower ack
    exp_rres = 32'hFFFF_FF80;
    sb_q.push_back(exp_rres);
    run_access(1'b1, 1'b0, F3_B, 32'h103, 32'h0, 32'h80FF_0000, 2);
    check("lb_stalls", 32'(stalls), 32'd4);
    check("lb_addr",   cap_addr, 32'h100);
    pop_check("lb_data");

    // lhu, zero extension of upper half
    exp_rres = 32'h0000_80FF;
    sb_q.push_back(exp_rres);
    run_access(1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 32'h80FF_0000, 0);
    pop_check("lhu_data");

    // lh, lower half sign-extended
    exp_rres = 32'hFFFF_F678;
    sb_q.push_back(exp_rres);
    run_access(1'b1, 1'b0, F3_H, 32'h000, 32'h0, 32'h1234_F678, 1);
    pop_check("lh_data");

    // lbu, byte lane 1
    exp_rres = 32'h0000_0056;
    sb_q.push_back(exp_rres);
    run_access(1'b1, 1'b0, F3_BU, 32'h101, 32'h0, 32'h1234_5678, 0);
    pop_check("lbu_data");

    // sb 0xAB @0x201
    sb_q.push_back(exp_rres);
    run_access(1'b0, 1'b1, F3_B, 32'h201, 32'h0000_00AB, 32'h9999_9999, 0);
    check("sb_addr",  cap_addr, 32'h200);
    check("sb_be",    32'(cap_be), 32'h2);
    check("sb_wdata", cap_wdata, 32'hABAB_ABAB);
    check("sb_we",    32'(cap_we), 32'd1);
    pop_check("sb_rres_unchanged");

    // sh to upper half
    sb_q.push_back(exp_rres);
    run_access(1'b0, 1'b1, F3_H, 32'h206, 32'h1234_CDEF, 32'h0, 0);
    check("sh_addr",  cap_addr, 32'h204);
    check("sh_be",    32'(cap_be), 32'hC);
    check("sh_wdata", cap_wdata, 32'hCDEF_CDEF);
    pop_check("sh_rres_unchanged");

    // sw
    run_access(1'b0, 1'b1, F3_W, 32'h208, 32'hCAFE_F00D, 32'h0, 0);
    check("sw_be",    32'(cap_be), 32'hF);
    check("sw_wdata", cap_wdata, 32'hCAFE_F00D);

    // read and write together behave as a store
    sb_q.push_back(exp_rres);
    run_access(1'b1, 1'b1, F3_W, 32'h300, 32'h5555_AAAA, 32'h7777_7777, 0);
    check("rw_we",    32'(cap_we), 32'd1);
    check("rw_wdata", cap_wdata, 32'h5555_AAAA);
    pop_check("rw_rres_unchanged");

    // misaligned lw: no bus transfer, no stall, one-cycle misalign pulse
    sb_q.push_back(exp_rres);
    run_access(1'b1, 1'b0, F3_W, 32'h102, 32'h0, 32'h0, 0);
    check("mis_pulse",  32'(misalign), 32'd1);
    check("mis_noreq",  32'(saw_req), 32'd0);
    check("mis_stalls", 32'(stalls), 32'd0);
    pop_check("mis_rres_unchanged");
    @(negedge clk);
    check("mis_pulse_end", 32'(misalign), 32'd0);
    check("mis_req_low",   32'(dbus_req), 32'd0);

    // misaligned sh
    run_access(1'b0, 1'b1, F3_H, 32'h201, 32'h0, 32'h0, 0);
    check("mis_sh_pulse", 32'(misalign), 32'd1);
    check("mis_sh_noreq", 32'(saw_req), 32'd0);

    // no ack: timeout after 5 REQ cycles with TIMEOUT = 4
    exp_rres = 32'hDEAD_BEEF;
    sb_q.push_back(exp_rres);
    run_access(1'b1, 1'b0, F3_W, 32'h400, 32'h0, 32'h0, -1);
    check("to_stalls", 32'(stalls), 32'd6);
    check("to_berr",   32'(bus_error), 32'd1);
    check("to_req",    32'(dbus_req), 32'd0);
    pop_check("to_data");
    @(negedge clk);
    check("to_berr_end", 32'(bus_error), 32'd0);
    check("to_idle",     32'(dut.state_q), 32'(ST_IDLE));

    // ack in the same cycle the counter reaches TIMEOUT: ack wins
    exp_rres = 32'h0F0F_1234;
    sb_q.push_back(exp_rres);
    run_access(1'b1, 1'b0, F3_W, 32'h404, 32'h0, 32'h0F0F_1234, 4);
    check("edge_stalls", 32'(stalls), 32'd6);
    check("edge_berr",   32'(bus_error), 32'd0);
    pop_check("edge_data");

    // reset while in REQ
    @(negedge clk);
    mem_mem_read   = 1'b1;
    mem_funct3     = F3_W;
    mem_alu_result = 32'h500;
    @(negedge clk);
    check("rstreq_req_pre", 32'(dbus_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstreq_stall", 32'(mem_stall), 32'd0);
    check("rstreq_req",   32'(dbus_req), 32'd0);
    check("rstreq_addr",  dbus_addr, 32'h0);
    check("rstreq_be",    32'(dbus_be), 32'd0);
    check("rstreq_rres",  mem_read_result, 32'h0);
    exp_rres = 32'h0;
    @(negedge clk);
    mem_mem_read = 1'b0;
    rst          = 1'b0;
    check("rstreq_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // clean lw after reset
    exp_rres = 32'h0BAD_F00D;
    sb_q.push_back(exp_rres);
    run_access(1'b1, 1'b0, F3_W, 32'h600, 32'h0, 32'h0BAD_F00D, 0);
    check("post_rst_stalls", 32'(stalls), 32'd2);
    check("post_rst_addr",   cap_addr, 32'h600);
    pop_check("post_rst_data");

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
